// File: rtl/fp32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fp32_pkg                                                         |
// | Brief   : Shared types and constants for the FP32 post-normalise stage     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Magnitude field of infinity (sign is attached at pack time) and the +0 word.
  localparam logic [30:0] c_inf_mag   = {EXP_MAX, {FRAC_W{1'b0}}};
  localparam logic [31:0] c_zero_word = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SPEC_NONE  = 2'd0,
    SPEC_INF   = 2'd1,
    SPEC_ZERO  = 2'd2,
    SPEC_UFLOW = 2'd3
  } spec_t;

endpackage
`default_nettype wire

// File: rtl/fp32_rounder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fp32_rounder                                                     |
// | Brief   : Combinational rounder; ROUND_NEAREST_EN selects RNE, else truncate|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fp32_rounder
  import fp32_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic [EXP_W:0]    exp,
`ifdef ROUND_NEAREST_EN
  input  logic [2:0]        grs,
`endif
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              ovf
);

  logic          w_carry;
  logic [EXP_W:0] w_exp;

`ifdef ROUND_NEAREST_EN
  logic w_inc;
  assign w_inc    = grs[2] & (grs[1] | grs[0] | frac[0]);
  // An all-ones fraction wraps to zero; the hidden bit moves up via the exponent.
  assign w_carry  = w_inc & (&frac);
  assign frac_out = frac + {{(FRAC_W-1){1'b0}}, w_inc};
`else
  assign w_carry  = 1'b0;
  assign frac_out = frac;
`endif

  assign w_exp   = exp + {{EXP_W{1'b0}}, w_carry};
  assign exp_out = w_exp[EXP_W-1:0];
  assign ovf     = (w_exp >= {1'b0, EXP_MAX});

endmodule
`default_nettype wire

// File: rtl/fp32_post_normalise.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fp32_post_normalise                                              |
// | Brief   : Iterative normalise, round and pack of FP32 add/sub result.      |
// |           ROUND_NEAREST_EN enables round-to-nearest-even (else truncate).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fp32_post_normalise
  import fp32_pkg::*;
#(
  parameter int MAX_SHIFT = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              carry_in,
  input  logic [2:0]        grs_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  state_t            r_state;
  state_t            w_next;
  spec_t             r_spec;
  spec_t             w_spec_in;
  logic              r_sign;
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W:0]    r_exp;
  logic [2:0]        r_grs;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_result;
  logic              r_ovf;
  logic              r_unf;
  logic              r_zero;
  logic              w_nuf;
  logic [FRAC_W-1:0] w_rfrac;
  logic [EXP_W-1:0]  w_rexp;
  logic              w_rovf;

  always_comb begin
    w_spec_in = SPEC_NONE;
    if (exp_in == EXP_MAX)
      w_spec_in = SPEC_INF;
    else if (mant_in == '0 && !carry_in && grs_in == 3'b000)
      w_spec_in = SPEC_ZERO;
    else if (carry_in && exp_in == EXP_MAX - 8'd1)
      w_spec_in = SPEC_INF;
    else if (exp_in == '0)
      w_spec_in = SPEC_UFLOW;
  end

  // Out of exponent range or out of shift budget before the hidden bit appears.
  assign w_nuf = ~r_mant[MANT_W-1] &
                 ((r_exp == {{EXP_W{1'b0}}, 1'b1}) || (r_cnt == CNT_W'(MAX_SHIFT)));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (in_valid) w_next = NORM;
      NORM:  if (r_spec != SPEC_NONE || r_mant[MANT_W-1] || w_nuf) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
    endcase
  end

  fp32_rounder u_rounder (
    .frac     (r_mant[FRAC_W-1:0]),
    .exp      (r_exp),
`ifdef ROUND_NEAREST_EN
    .grs      (r_grs),
`endif
    .frac_out (w_rfrac),
    .exp_out  (w_rexp),
    .ovf      (w_rovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_spec   <= SPEC_NONE;
      r_sign   <= 1'b0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_grs    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_sign <= sign_in;
          r_spec <= w_spec_in;
          r_cnt  <= '0;
          r_ovf  <= 1'b0;
          r_unf  <= 1'b0;
          r_zero <= 1'b0;
          if (carry_in) begin
            r_mant <= {1'b1, mant_in[MANT_W-1:1]};
            r_exp  <= {1'b0, exp_in} + {{EXP_W{1'b0}}, 1'b1};
            r_grs  <= {mant_in[0], 1'b0, |grs_in};
          end else begin
            r_mant <= mant_in;
            r_exp  <= {1'b0, exp_in};
            r_grs  <= grs_in;
          end
        end
        NORM: if (r_spec == SPEC_NONE && !r_mant[MANT_W-1]) begin
          if (w_nuf) begin
            r_spec <= SPEC_UFLOW;
          end else begin
            r_mant <= {r_mant[MANT_W-2:0], r_grs[2]};
            r_grs  <= {r_grs[1], 1'b0, r_grs[0]};
            r_exp  <= r_exp - {{EXP_W{1'b0}}, 1'b1};
            r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ROUND: begin
          unique case (r_spec)
            SPEC_INF: begin
              r_result <= {r_sign, c_inf_mag};
              r_ovf    <= 1'b1;
            end
            SPEC_ZERO: begin
              r_result <= c_zero_word;
              r_zero   <= 1'b1;
            end
            SPEC_UFLOW: begin
              r_result <= {r_sign, 31'h0};
              r_unf    <= 1'b1;
              r_zero   <= 1'b1;
            end
            SPEC_NONE: begin
              if (w_rovf) begin
                r_result <= {r_sign, c_inf_mag};
                r_ovf    <= 1'b1;
              end else begin
                r_result <= {r_sign, w_rexp, w_rfrac};
              end
            end
          endcase
        end
        DONE: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_fp32_post_normalise.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fp32_post_normalise                                           |
// | Brief   : Directed and random checks against a value-level reference model |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fp32_post_normalise;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, sign_in, carry_in;
  logic [7:0]  exp_in;
  logic [23:0] mant_in;
  logic [2:0]  grs_in;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        zro;
    logic [7:0]  lat;
  } exp_t;

  fp32_post_normalise dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .carry_in(carry_in),
    .grs_in(grs_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Value-level model: treat {mant,G,R} as a bit string, count leading zeros,
  // and decide underflow from how far the exponent and shift budget allow.
  function automatic exp_t model(input logic s, input logic [7:0] e, input logic [23:0] m,
                                 input logic c, input logic [2:0] g);
    exp_t        r;
    logic [25:0] w;
    logic [24:0] mt;
    logic        gb, rb, sb, inc;
    int          ex, lz, lim;
    r = '0;
    r.lat = 8'd2;
    if (e == 8'hFF) begin r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; return r; end
    if (m == 24'h0 && !c && g == 3'b000) begin r.res = 32'h0; r.zro = 1'b1; return r; end
    if (c && e == 8'hFE) begin r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; return r; end
    if (e == 8'h00) begin r.res = {s, 31'h0}; r.unf = 1'b1; r.zro = 1'b1; return r; end
    if (c) begin
      mt = {2'b01, m[23:1]};
      gb = m[0]; rb = 1'b0; sb = |g;
      ex = int'(e) + 1;
    end else begin
      w  = {m, g[2], g[1]};
      sb = g[0];
      lz = 0;
      while (lz < 26 && !w[25-lz]) lz++;
      lim = (int'(e) - 1 < 23) ? int'(e) - 1 : 23;
      if (lz > lim) begin
        r.res = {s, 31'h0}; r.unf = 1'b1; r.zro = 1'b1; r.lat = 8'(lim + 2);
        return r;
      end
      w  = w << lz;
      mt = {1'b0, w[25:2]};
      gb = w[1]; rb = w[0];
      ex = int'(e) - lz;
      r.lat = 8'(lz + 2);
    end
`ifdef ROUND_NEAREST_EN
    inc = gb & (rb | sb | mt[0]);
`else
    inc = 1'b0;
`endif
    mt = mt + {24'h0, inc};
    if (mt[24]) begin mt = 25'h0800000; ex = ex + 1; end
    if (ex >= 255) begin r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; end
    else r.res = {s, 8'(ex), mt[22:0]};
    return r;
  endfunction

  task automatic start_op(input logic s, input logic [7:0] e, input logic [23:0] m,
                          input logic c, input logic [2:0] g);
    int t = 0;
    while (!in_ready && t < 60) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_wait: in_ready=%0b required 1", in_ready);
    end
    sign_in = s; exp_in = e; mant_in = m; carry_in = c; grs_in = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sign_in = 0; exp_in = 0; mant_in = 0; carry_in = 0; grs_in = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, result, overflow, underflow, zero} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%0b vld=%0b res=%h flags=%b required rdy=1 vld=0 res=0 flags=000",
               in_ready, out_valid, result, {overflow, underflow, zero});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic exp_t vec_spec(input int i, output logic s, output logic [7:0] e,
                                    output logic [23:0] m, output logic c, output logic [2:0] g);
    exp_t r;
    r = '0; r.lat = 8'd2;
    s = 0; c = 0; g = 3'b000;
    case (i)
      0: begin e = 8'h80; m = 24'hC00000; r.res = 32'h40400000; end
      1: begin e = 8'h7F; m = 24'h400000; c = 1; r.res = 32'h40200000; end
      2: begin e = 8'h90; m = 24'h000001; r.res = 32'h3C800000; r.lat = 8'd25; end
      3: begin e = 8'h7F; m = 24'hFFFFFF; g = 3'b100;
`ifdef ROUND_NEAREST_EN
         r.res = 32'h40000000;
`else
         r.res = 32'h3FFFFFFF;
`endif
         end
      4: begin s = 1; e = 8'hFE; m = 24'h800000; c = 1; r.res = 32'hFF800000; r.ovf = 1; end
      5: begin e = 8'h55; m = 24'h000000; r.res = 32'h0; r.zro = 1; end
      6: begin s = 1; e = 8'h02; m = 24'h000100; r.res = 32'h80000000; r.unf = 1; r.zro = 1; r.lat = 8'd3; end
      7: begin e = 8'hFF; m = 24'h123456; r.res = 32'h7F800000; r.ovf = 1; end
      default: begin e = 8'hFE; m = 24'hFFFFFF; g = 3'b100;
`ifdef ROUND_NEAREST_EN
         r.res = 32'h7F800000; r.ovf = 1;
`else
         r.res = 32'h7F7FFFFF;
`endif
         end
    endcase
    return r;
  endfunction

  task automatic test_directed();
    logic s, c; logic [7:0] e; logic [23:0] m; logic [2:0] g;
    exp_t want; int lat;
    for (int i = 0; i < 9; i++) begin
      want = vec_spec(i, s, e, m, c, g);
      start_op(s, e, m, c, g);
      n_cmp++;
      if ({overflow, underflow, zero} !== 3'b000) begin
        n_bad++;
        $display("FAIL flags_clear[%0d]: flags=%b required 000", i, {overflow, underflow, zero});
      end
      wait_done(lat);
      n_cmp++;
      if ({result, overflow, underflow, zero} !== {want.res, want.ovf, want.unf, want.zro}) begin
        n_bad++;
        $display("FAIL directed[%0d]: res=%h flags=%b required res=%h flags=%b",
                 i, result, {overflow, underflow, zero}, want.res, {want.ovf, want.unf, want.zro});
      end
      n_cmp++;
      if (lat !== int'(want.lat)) begin
        n_bad++;
        $display("FAIL directed_lat[%0d]: latency=%0d required %0d", i, lat, want.lat);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic s, c; logic [7:0] e; logic [23:0] m; logic [2:0] g;
    exp_t want; int lat, sel;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      sel = $urandom_range(0, 19);
      case (sel)
        0: e = 8'h00;
        1: e = 8'hFF;
        2: e = 8'hFE;
        3: e = 8'h01;
        4: e = 8'(2 + $urandom_range(0, 20));
        default: e = 8'($urandom_range(1, 254));
      endcase
      m = 24'($urandom) >> $urandom_range(0, 24);
      c = ($urandom_range(0, 3) == 0);
      g = 3'($urandom);
      want = model(s, e, m, c, g);
      start_op(s, e, m, c, g);
      wait_done(lat);
      n_cmp++;
      if ({result, overflow, underflow, zero} !== {want.res, want.ovf, want.unf, want.zro}
          || lat !== int'(want.lat)) begin
        n_bad++;
        $display("FAIL random[%0d] in s=%b e=%h m=%h c=%b g=%b: res=%h flags=%b lat=%0d required res=%h flags=%b lat=%0d",
                 i, s, e, m, c, g, result, {overflow, underflow, zero}, lat,
                 want.res, {want.ovf, want.unf, want.zro}, want.lat);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t want; int lat;
    want = model(1'b1, 8'h02, 24'h000100, 1'b0, 3'b000);
    start_op(1'b1, 8'h02, 24'h000100, 1'b0, 3'b000);
    wait_done(lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, result, overflow, underflow, zero} !== {1'b1, want.res, want.ovf, want.unf, want.zro}) begin
        n_bad++;
        $display("FAIL hold[%0d]: vld=%0b res=%h flags=%b required vld=1 res=%h flags=%b",
                 k, out_valid, result, {overflow, underflow, zero}, want.res, {want.ovf, want.unf, want.zro});
      end
    end
    release_out();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL release: vld=%0b rdy=%0b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    start_op(1'b0, 8'h90, 24'h000001, 1'b0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: vld=%0b rdy=%0b res=%h required vld=0 rdy=1 res=0",
               out_valid, in_ready, result);
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_stall();
    exp_t want; int lat;
    en = 1'b0; in_valid = 1'b1;
    sign_in = 0; exp_in = 8'h80; mant_in = 24'hC00000; carry_in = 0; grs_in = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; en = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_accept: in_ready=%0b required 1", in_ready);
    end
    want = model(1'b0, 8'h80, 24'h001000, 1'b0, 3'b010);
    start_op(1'b0, 8'h80, 24'h001000, 1'b0, 3'b010);
    lat = 0;
    while (!out_valid && lat < 80) begin
      if (lat == 2) en = 1'b0;
      if (lat == 7) en = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    en = 1'b1;
    n_cmp++;
    if (result !== want.res || lat !== int'(want.lat) + 5) begin
      n_bad++;
      $display("FAIL stall: res=%h lat=%0d required res=%h lat=%0d",
               result, lat, want.res, int'(want.lat) + 5);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
